// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: hazard sources from ID/EX in, stage enables/flushes out.
// Pure wiring, no latency; no backpressure, controls are consumed every cycle.
// master = core/pipeline side, slave = hazard controller.
interface pipeline_hazard_controller_if #(
    parameter int REG_ADDR_BITS = 5
);
    logic [REG_ADDR_BITS-1:0] id_rs_i;
    logic [REG_ADDR_BITS-1:0] id_rt_i;
    logic                     id_uses_rt_i;
    logic                     ex_mem_read_i;
    logic [REG_ADDR_BITS-1:0] ex_rt_i;
    logic                     ex_muldiv_i;
    logic                     branch_taken_i;

    logic                     pc_enable_o;
    logic                     ifid_enable_o;
    logic                     idex_enable_o;
    logic                     exmem_enable_o;
    logic                     memwb_enable_o;
    logic                     ifid_flush_o;
    logic                     idex_flush_o;
    logic                     memwb_flush_o;
    logic                     muldiv_busy_o;
    logic                     muldiv_done_o;
    logic [15:0]              load_use_count_o;
    logic [15:0]              muldiv_stall_count_o;
    logic [15:0]              flush_count_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
               ex_muldiv_i, branch_taken_i,
        input  pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
               memwb_enable_o, ifid_flush_o, idex_flush_o, memwb_flush_o,
               muldiv_busy_o, muldiv_done_o, load_use_count_o,
               muldiv_stall_count_o, flush_count_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
               ex_muldiv_i, branch_taken_i,
        output pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
               memwb_enable_o, ifid_flush_o, idex_flush_o, memwb_flush_o,
               muldiv_busy_o, muldiv_done_o, load_use_count_o,
               muldiv_stall_count_o, flush_count_o
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stage enable/flush generator: load-use stalls, mult/div stall sequencing, branch flushes.
// Controls are Mealy combinational (same cycle); state advances on the falling clock edge.
// No backpressure: stalls are expressed purely through the stage enables. Perf counters: STALL_PERF_COUNTERS_EN.
module pipeline_hazard_controller #(
    parameter int MULDIV_CYCLES = 32,   // total mult/div stall cycles, >= 2
    parameter int REG_ADDR_BITS = 5
) (
    input logic                           clk,
    input logic                           reset,
    pipeline_hazard_controller_if.slave   hz
);
    localparam int             CNT_W    = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   md_cnt;

    logic [REG_ADDR_BITS-1:0] ex_rt;
    logic                     load_use;
    logic                     md_stall;
    logic                     lu_stall;
    logic                     br_flush;

    assign ex_rt    = hz.ex_rt_i;
    assign load_use = hz.ex_mem_read_i && (ex_rt != '0) &&
                      ((ex_rt == hz.id_rs_i) || (hz.id_uses_rt_i && (ex_rt == hz.id_rt_i)));

    // In MD_DONE the mult/div is still sitting in ID/EX, so ex_muldiv_i must not re-trigger.
    assign md_stall = reset && ((state == MD_BUSY) || ((state == RUN) && hz.ex_muldiv_i));
    assign lu_stall = reset && !md_stall && load_use;
    assign br_flush = reset && !md_stall && !lu_stall && hz.branch_taken_i;

    assign hz.pc_enable_o    = reset && !md_stall && !lu_stall;
    assign hz.ifid_enable_o  = reset && !md_stall && !lu_stall;
    assign hz.idex_enable_o  = reset && !md_stall;
    assign hz.exmem_enable_o = reset && !md_stall;
    assign hz.memwb_enable_o = reset;
    assign hz.ifid_flush_o   = br_flush;
    assign hz.idex_flush_o   = lu_stall;
    assign hz.memwb_flush_o  = md_stall;
    assign hz.muldiv_busy_o  = md_stall;
    assign hz.muldiv_done_o  = reset && (state == MD_DONE);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_muldiv_i) begin
                        state  <= MD_BUSY;
                        md_cnt <= CNT_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt == '0) begin
                        state <= MD_DONE;
                    end else begin
                        md_cnt <= md_cnt - CNT_W'(1);
                    end
                end
                MD_DONE: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef STALL_PERF_COUNTERS_EN
    logic [15:0] lu_cnt;
    logic [15:0] md_stall_cnt;
    logic [15:0] fl_cnt;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            lu_cnt       <= '0;
            md_stall_cnt <= '0;
            fl_cnt       <= '0;
        end else begin
            if (lu_stall && (lu_cnt != 16'hFFFF)) begin
                lu_cnt <= lu_cnt + 16'd1;
            end
            if (md_stall && (md_stall_cnt != 16'hFFFF)) begin
                md_stall_cnt <= md_stall_cnt + 16'd1;
            end
            if (br_flush && (fl_cnt != 16'hFFFF)) begin
                fl_cnt <= fl_cnt + 16'd1;
            end
        end
    end

    assign hz.load_use_count_o     = lu_cnt;
    assign hz.muldiv_stall_count_o = md_stall_cnt;
    assign hz.flush_count_o        = fl_cnt;
`else
    assign hz.load_use_count_o     = '0;
    assign hz.muldiv_stall_count_o = '0;
    assign hz.flush_count_o        = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (MULDIV_CYCLES 4 and 32) on shared inputs,
// a cycle-level reference model compared every cycle, plus literal expectations at key points.
module tb_pipeline_hazard_controller;
    localparam int RB   = 5;
    localparam int MC0  = 4;
    localparam int MC1  = 32;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_flush, busy, done}
    localparam logic [9:0] O_ZERO = 10'b00000_000_00;
    localparam logic [9:0] O_IDLE = 10'b11111_000_00;
    localparam logic [9:0] O_LU   = 10'b00111_010_00;
    localparam logic [9:0] O_BR   = 10'b11111_100_00;
    localparam logic [9:0] O_MD   = 10'b00001_001_10;
    localparam logic [9:0] O_DONE = 10'b11111_000_01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [RB-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic          uses = 1'b0, rd = 1'b0, md = 1'b0, br = 1'b0;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller_if #(.REG_ADDR_BITS(RB)) if4 ();
    pipeline_hazard_controller_if #(.REG_ADDR_BITS(RB)) if32 ();

    assign if4.id_rs_i = id_rs;   assign if32.id_rs_i = id_rs;
    assign if4.id_rt_i = id_rt;   assign if32.id_rt_i = id_rt;
    assign if4.ex_rt_i = ex_rt;   assign if32.ex_rt_i = ex_rt;
    assign if4.id_uses_rt_i   = uses; assign if32.id_uses_rt_i   = uses;
    assign if4.ex_mem_read_i  = rd;   assign if32.ex_mem_read_i  = rd;
    assign if4.ex_muldiv_i    = md;   assign if32.ex_muldiv_i    = md;
    assign if4.branch_taken_i = br;   assign if32.branch_taken_i = br;

    pipeline_hazard_controller #(.MULDIV_CYCLES(MC0), .REG_ADDR_BITS(RB)) dut4 (
        .clk(clk), .reset(reset), .hz(if4.slave));
    pipeline_hazard_controller #(.MULDIV_CYCLES(MC1), .REG_ADDR_BITS(RB)) dut32 (
        .clk(clk), .reset(reset), .hz(if32.slave));

    logic [9:0]  o    [2];
    logic [15:0] c_lu [2];
    logic [15:0] c_md [2];
    logic [15:0] c_fl [2];

    assign o[0] = {if4.pc_enable_o, if4.ifid_enable_o, if4.idex_enable_o, if4.exmem_enable_o,
                   if4.memwb_enable_o, if4.ifid_flush_o, if4.idex_flush_o, if4.memwb_flush_o,
                   if4.muldiv_busy_o, if4.muldiv_done_o};
    assign o[1] = {if32.pc_enable_o, if32.ifid_enable_o, if32.idex_enable_o, if32.exmem_enable_o,
                   if32.memwb_enable_o, if32.ifid_flush_o, if32.idex_flush_o, if32.memwb_flush_o,
                   if32.muldiv_busy_o, if32.muldiv_done_o};
    assign c_lu[0] = if4.load_use_count_o;      assign c_lu[1] = if32.load_use_count_o;
    assign c_md[0] = if4.muldiv_stall_count_o;  assign c_md[1] = if32.muldiv_stall_count_o;
    assign c_fl[0] = if4.flush_count_o;         assign c_fl[1] = if32.flush_count_o;

    // Reference model: remaining stall cycles after the current one, and a pending done pulse.
    int rem  [2] = '{0, 0};
    bit dn   [2] = '{0, 0};
    int m_lu [2] = '{0, 0};
    int m_md [2] = '{0, 0};
    int m_fl [2] = '{0, 0};

    function automatic int mc(int k);
        return (k == 0) ? MC0 : MC1;
    endfunction

    function automatic bit hazard();
        return rd && (ex_rt != 0) && ((ex_rt == id_rs) || (uses && (ex_rt == id_rt)));
    endfunction

    function automatic bit m_busy(int k);
        return (rem[k] > 0) || (!dn[k] && md);
    endfunction

    function automatic logic [9:0] expect_out(int k);
        logic [9:0] r;
        if (!reset) return O_ZERO;
        if (m_busy(k)) return O_MD;
        if (hazard())  r = O_LU;
        else if (br)   r = O_BR;
        else           r = O_IDLE;
        r[0] = dn[k];
        return r;
    endfunction

    always @(negedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                rem[k] = 0; dn[k] = 0; m_lu[k] = 0; m_md[k] = 0; m_fl[k] = 0;
            end else begin
                logic [9:0] e;
                e = expect_out(k);
                if (e[3] && m_lu[k] < 16'hFFFF) m_lu[k]++;
                if (e[1] && m_md[k] < 16'hFFFF) m_md[k]++;
                if (e[4] && m_fl[k] < 16'hFFFF) m_fl[k]++;
                if (dn[k]) begin
                    dn[k] = 0;
                end else if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) dn[k] = 1;
                end else if (md) begin
                    rem[k] = mc(k) - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison, late in the high phase, well clear of the falling update edge.
    always @(posedge clk) begin
        #4;
        for (int k = 0; k < 2; k++) begin
            chk(k == 0 ? "model_out4" : "model_out32", {22'd0, o[k]}, {22'd0, expect_out(k)});
`ifdef STALL_PERF_COUNTERS_EN
            chk("model_lu_cnt", {16'd0, c_lu[k]}, m_lu[k]);
            chk("model_md_cnt", {16'd0, c_md[k]}, m_md[k]);
            chk("model_fl_cnt", {16'd0, c_fl[k]}, m_fl[k]);
`else
            chk("tied_cnt", {c_lu[k], c_md[k] | c_fl[k]}, 32'd0);
`endif
        end
    end

    task automatic drive(input logic r, input logic [RB-1:0] ert, input logic [RB-1:0] rs,
                         input logic [RB-1:0] rt, input logic u, input logic m, input logic b);
        @(posedge clk);
        #1;
        rd = r; ex_rt = ert; id_rs = rs; id_rt = rt; uses = u; md = m; br = b;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2 reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive(i[0], 5'd8, 5'd8, 5'(i), 1'b1, i[1], 1'b1);
            chk("reset_out4", {22'd0, o[0]}, {22'd0, O_ZERO});
            chk("reset_out32", {22'd0, o[1]}, {22'd0, O_ZERO});
        end

        @(posedge clk);
        #1 reset = 1'b1;
        rd = 0; ex_rt = 0; id_rs = 0; id_rt = 0; uses = 0; md = 0; br = 0;
        #2 chk("idle_after_reset", {22'd0, o[0]}, {22'd0, O_IDLE});

        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_rs", {22'd0, o[0]}, {22'd0, O_LU});
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("lu_rt_zero", {22'd0, o[0]}, {22'd0, O_IDLE});
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("lu_rt", {22'd0, o[0]}, {22'd0, O_LU});
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
        chk("rt_not_used", {22'd0, o[0]}, {22'd0, O_IDLE});
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("lu_beats_branch", {22'd0, o[0]}, {22'd0, O_LU});
        drive(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("branch_flush", {22'd0, o[0]}, {22'd0, O_BR});

        // Mult/div with a simultaneous load-use and branch: both ignored.
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("md_detect4", {22'd0, o[0]}, {22'd0, O_MD});
        chk("md_detect32", {22'd0, o[1]}, {22'd0, O_MD});
        for (int i = 0; i < MC0 - 1; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk("md_busy4", {22'd0, o[0]}, {22'd0, O_MD});
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("md_done4", {22'd0, o[0]}, {22'd0, O_DONE});
        chk("md_still_busy32", {22'd0, o[1]}, {22'd0, O_MD});
        idle();
        chk("md_back_to_run4", {22'd0, o[0]}, {22'd0, O_IDLE});
        repeat (34) idle();

        // Abort a 32-cycle stall at its second cycle.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("md_stall2_32", {22'd0, o[1]}, {22'd0, O_MD});
        reset = 1'b0;
        #1;
        chk("abort_zero32", {22'd0, o[1]}, {22'd0, O_ZERO});
        @(posedge clk);
        #1 reset = 1'b1;
        md = 1'b0;
        #2;
        chk("abort_run32", {22'd0, o[1]}, {22'd0, O_IDLE});
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("abort_no_done32", {22'd0, o[1]}, {22'd0, O_IDLE});
        end

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd12, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0);
            idle();
        end
        repeat (MC0 + 1) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
`ifdef STALL_PERF_COUNTERS_EN
        chk("perf_lu_count", {16'd0, c_lu[0]}, 32'd3);
        chk("perf_md_count", {16'd0, c_md[0]}, 32'd4);
`else
        chk("perf_lu_tied", {16'd0, c_lu[0]}, 32'd0);
        chk("perf_md_tied", {16'd0, c_md[0]}, 32'd0);
`endif
        repeat (40) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Generates the per-stage enable and flush controls consumed by the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and by the PC register.
- Detects load-use hazards, sequences multi-cycle mult/div stalls with an internal counter, and converts taken branches into IF/ID flushes.
- Sits beside the hazard/forwarding logic in the core top level.

Parameters:
- MULDIV_CYCLES, 32, total stall cycles for a mult/div in EX; must be at least 2.
- REG_ADDR_BITS, 5, register-specifier width.

Ports:
- clk  in  1  core clock; all state updates on the falling edge, matching the pipeline registers.
- reset  in  1  asynchronous, active-low reset.
- id_rs_i  in  REG_ADDR_BITS  rs specifier of the instruction in ID.
- id_rt_i  in  REG_ADDR_BITS  rt specifier of the instruction in ID.
- id_uses_rt_i  in  1  instruction in ID reads rt.
- ex_mem_read_i  in  1  instruction in EX is a load.
- ex_rt_i  in  REG_ADDR_BITS  destination of the load in EX.
- ex_muldiv_i  in  1  instruction in EX is mult/div.
- branch_taken_i  in  1  branch resolved taken in ID.
- pc_enable_o  out  1  PC register enable.
- ifid_enable_o  out  1  IF/ID register enable.
- idex_enable_o  out  1  ID/EX register enable.
- exmem_enable_o  out  1  EX/MEM register enable.
- memwb_enable_o  out  1  MEM/WB register enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_flush_o  out  1  ID/EX loads a bubble.
- memwb_flush_o  out  1  MEM/WB loads a bubble.
- muldiv_busy_o  out  1  mult/div stall in progress.
- muldiv_done_o  out  1  mult/div result advances this cycle.
- load_use_count_o  out  16  load-use stall count (optional feature).
- muldiv_stall_count_o  out  16  mult/div stall cycle count (optional feature).
- flush_count_o  out  16  branch flush count (optional feature).

Behaviour:
- While reset=0: state RUN, counter 0, every output 0, including enables. No latching of inputs.
- States are RUN, MD_BUSY and MD_DONE. Outputs are Mealy combinational from state and inputs. The default is all enables 1 and all flushes 0.
- load_use = ex_mem_read_i & (ex_rt_i != 0) & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & ex_rt_i == id_rt_i)).
- RUN with ex_muldiv_i=1:
  - Set pc/ifid/idex/exmem enables to 0, memwb_enable_o=1, memwb_flush_o=1, muldiv_busy_o=1.
  - Load counter with MULDIV_CYCLES-2 and go to MD_BUSY.
  - load_use and branch_taken_i are ignored.
- RUN with load_use (no muldiv):
  - pc_enable_o=0, ifid_enable_o=0, idex_flush_o=1; exmem and memwb enabled.
  - branch_taken_i is ignored; the stalled branch re-resolves next cycle.
- RUN with branch_taken_i only: ifid_flush_o=1, all enables 1.
- MD_BUSY:
  - Outputs are the same as the mult/div detection cycle.
  - Counter decrements each edge; when counter==0, go to MD_DONE.
  - Total stall = MULDIV_CYCLES cycles, including the detection cycle.
- MD_DONE:
  - muldiv_done_o=1 and all enables 1, so the result enters EX/MEM.
  - ex_muldiv_i is ignored because the same instruction is still in ID/EX.
  - load_use and branch rules apply as in RUN. Next state is RUN.
- Counter width is clog2(MULDIV_CYCLES) and it never wraps.
- Reset asserted mid-stall aborts immediately to RUN with the counter cleared; no done pulse.
- Priority: reset > muldiv (RUN or MD_BUSY) > load_use > branch flush.

Optional Feature:
- STALL_PERF_COUNTERS_EN defined:
  - The three 16-bit counters are implemented and cleared by reset.
  - load_use_count_o increments once per load-use stall cycle.
  - muldiv_stall_count_o increments on every cycle with muldiv_busy_o=1.
  - flush_count_o increments on every cycle with ifid_flush_o=1.
  - All three counters saturate at 16'hFFFF.
- Undefined: the counters are not built and the three ports are tied to 0.

Test Plan:
- Reset held low, inputs toggling -> all outputs 0; after release with idle inputs, all enables 1 and all flushes 0.
- ex_mem_read_i=1, ex_rt_i=8, id_rs_i=8 for one cycle -> pc/ifid enables 0 and idex_flush_o=1 for that cycle; with ex_rt_i=0 -> no stall.
- ex_muldiv_i=1 with MULDIV_CYCLES=4 -> muldiv_busy_o high for exactly 4 cycles with memwb_flush_o=1, then muldiv_done_o for 1 cycle, then RUN.
- Load-use and branch_taken_i in the same cycle -> stall only, ifid_flush_o=0; next cycle with hazard cleared and branch_taken_i=1 -> ifid_flush_o=1.
- Reset pulsed low at stall cycle 2 of a 32-cycle mult/div -> outputs 0 immediately; after release, RUN with all enables 1 and no done pulse.
- STALL_PERF_COUNTERS_EN defined, 3 load-use stalls plus 1 mult/div with MULDIV_CYCLES=4 -> load_use_count_o=3 and muldiv_stall_count_o=4.
